// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// state codes, opcode/funct fields, ALU and load-type selects, fault codes.
package mc_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLL  = 3'd2;
    localparam logic [2:0] ALU_SRL  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LW   = 2'd1;
    localparam logic [1:0] MEM_LH   = 2'd2;
    localparam logic [1:0] MEM_LHU  = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational instruction classifier: maps latched opcode/funct to
// legality and the static datapath controls of that instruction.
module mc_instr_decode
    import mc_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic [2:0] alu_sel,
    output logic       alu_src,
    output logic       reg_dst,
    output logic [1:0] mem_read,
    output logic       mem_write,
    output logic       is_branch
);

    // Opcode/funct lookup; anything not listed is illegal.
    always_comb begin
        legal     = 1'b0;
        alu_sel   = ALU_ADD;
        alu_src   = 1'b0;
        reg_dst   = 1'b0;
        mem_read  = MEM_NONE;
        mem_write = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                legal   = 1'b1;
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_SLL:  alu_sel = ALU_SLL;
                    FN_SRL:  alu_sel = ALU_SRL;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    FN_SLTU: alu_sel = ALU_SLTU;
                    default: legal   = 1'b0;
                endcase
            end
            OP_LW:   begin legal = 1'b1; alu_src = 1'b1; mem_read = MEM_LW;  end
            OP_LH:   begin legal = 1'b1; alu_src = 1'b1; mem_read = MEM_LH;  end
            OP_LHU:  begin legal = 1'b1; alu_src = 1'b1; mem_read = MEM_LHU; end
            OP_SW:   begin legal = 1'b1; alu_src = 1'b1; mem_write = 1'b1;   end
            OP_BEQ:  begin legal = 1'b1; alu_sel = ALU_SUB; is_branch = 1'b1; end
            OP_ADDI: begin legal = 1'b1; alu_src = 1'b1; alu_sel = ALU_ADD;  end
            OP_ANDI: begin legal = 1'b1; alu_src = 1'b1; alu_sel = ALU_AND;  end
            OP_ORI:  begin legal = 1'b1; alu_src = 1'b1; alu_sel = ALU_OR;   end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer with a req/ready data-memory handshake.
// Optional performance counters are built when MC_CONTROL_PERF_EN is defined.
//
//  state  | meaning
//  FETCH  | wait for run, latch instruction fields, pulse ir_write
//  DECODE | legality check; illegal instructions trap to HALT
//  EXEC   | ALU operation; BEQ resolves and commits PC here
//  MEM    | data memory request held until mem_ready or timeout
//  WB     | register writeback and PC+4 commit
//  HALT   | sticky trap, left only through reset
module mc_control_fsm
    import mc_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_dst,
    output logic             alu_src,
    output logic [2:0]       alu_sel,
    output logic             mem_req,
    output logic [1:0]       mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault
`ifdef MC_CONTROL_PERF_EN
   ,output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
`endif
);

    // Wait counter value on the last MEM cycle allowed before the timeout trap.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [1:0] fault_q;
    logic [7:0] wait_q;

    logic       dec_legal;
    logic [2:0] dec_alu_sel;
    logic       dec_alu_src;
    logic       dec_reg_dst;
    logic [1:0] dec_mem_read;
    logic       dec_mem_write;
    logic       dec_is_branch;

    mc_instr_decode u_decode (
        .opcode    (op_q),
        .funct     (fn_q),
        .legal     (dec_legal),
        .alu_sel   (dec_alu_sel),
        .alu_src   (dec_alu_src),
        .reg_dst   (dec_reg_dst),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .is_branch (dec_is_branch)
    );

    // State sequencing, instruction latch, fault capture and memory wait counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        op_q    <= opcode;
                        fn_q    <= funct;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_HALT;
                        fault_q <= FAULT_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (dec_is_branch)
                        state_q <= S_FETCH;
                    else if (dec_mem_write || (dec_mem_read != MEM_NONE))
                        state_q <= S_MEM;
                    else
                        state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_q  <= '0;
                        state_q <= dec_mem_write ? S_FETCH : S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= S_HALT;
                        fault_q <= FAULT_TIMEOUT;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Output decode from the state register; reset forces everything low so an
    // aborted instruction cannot commit PC or register file in the reset cycle.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_sel    = ALU_ADD;
        mem_req    = 1'b0;
        mem_read   = MEM_NONE;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        state      = 3'd0;
        halted     = 1'b0;
        fault      = FAULT_NONE;
        if (reset) begin
            state = state_q;
            fault = fault_q;
            case (state_q)
                S_FETCH: ir_write = run;
                S_EXEC: begin
                    alu_sel = dec_alu_sel;
                    alu_src = dec_alu_src;
                    if (dec_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                end
                S_MEM: begin
                    alu_sel   = ALU_ADD;
                    alu_src   = 1'b1;
                    mem_req   = 1'b1;
                    mem_read  = dec_mem_read;
                    mem_write = dec_mem_write;
                    pc_write  = dec_mem_write & mem_ready;
                end
                S_WB: begin
                    alu_sel    = dec_alu_sel;
                    alu_src    = dec_alu_src;
                    reg_dst    = dec_reg_dst;
                    mem_read   = dec_mem_read;
                    mem_to_reg = (dec_mem_read != MEM_NONE);
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_CONTROL_PERF_EN
    // Active-cycle and committed-instruction counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if ((state_q != S_HALT) && (run || (state_q != S_FETCH)))
                cycle_count <= cycle_count + 1'b1;
            if (pc_write)
                instr_count <= instr_count + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_perf;
    assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver computes the expected
// output events of each instruction from the instruction-set rules and
// queues them; a negedge monitor pops and compares whenever the DUT shows
// activity (ir_write, pc_write, reg_write, mem_req, or entry into HALT).
module tb_mc_control_fsm;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset, run, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       ir_write, pc_write, pc_src, reg_dst, alu_src;
    logic [2:0] alu_sel;
    logic       mem_req;
    logic [1:0] mem_read;
    logic       mem_write, mem_to_reg, reg_write;
    logic [2:0] state;
    logic       halted;
    logic [1:0] fault;
`ifdef MC_CONTROL_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst),
        .alu_src(alu_src), .alu_sel(alu_sel), .mem_req(mem_req),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .state(state), .halted(halted), .fault(fault)
`ifdef MC_CONTROL_PERF_EN
       ,.cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ir_write, pc_write, pc_src, reg_dst, alu_src;
        logic [2:0] alu_sel;
        logic       mem_req;
        logic [1:0] mem_read;
        logic       mem_write, mem_to_reg, reg_write, halted;
        logic [1:0] fault;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instruction-set reference tables; R-type funct index equals ALU select.
    int         rfn[8]      = '{32, 34, 0, 2, 36, 37, 42, 43};
    logic [5:0] legal_ops[11] = '{0, 0, 0, 8, 12, 13, 35, 33, 37, 43, 4};
    logic [5:0] mem_ops[4]  = '{35, 33, 37, 43};

    function automatic out_t dut_out();
        out_t o;
        o.ir_write = ir_write;   o.pc_write = pc_write;     o.pc_src = pc_src;
        o.reg_dst = reg_dst;     o.alu_src = alu_src;       o.alu_sel = alu_sel;
        o.mem_req = mem_req;     o.mem_read = mem_read;     o.mem_write = mem_write;
        o.mem_to_reg = mem_to_reg; o.reg_write = reg_write; o.halted = halted;
        o.fault = fault;
        return o;
    endfunction

    // cls: 0 illegal, 1 R-type, 2 immediate, 3 load, 4 store, 5 branch
    function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                     output int cls, output logic [2:0] alu,
                                     output logic [1:0] mr);
        cls = 0; alu = 3'd0; mr = 2'd0;
        if (op == 6'd0) begin
            for (int k = 0; k < 8; k++)
                if (int'(fn) == rfn[k]) begin cls = 1; alu = 3'(k); end
        end
        else if (op == 6'd8)  begin cls = 2; alu = 3'd0; end
        else if (op == 6'd12) begin cls = 2; alu = 3'd4; end
        else if (op == 6'd13) begin cls = 2; alu = 3'd5; end
        else if (op == 6'd35) begin cls = 3; mr = 2'd1; end
        else if (op == 6'd33) begin cls = 3; mr = 2'd2; end
        else if (op == 6'd37) begin cls = 3; mr = 2'd3; end
        else if (op == 6'd43) begin cls = 4; end
        else if (op == 6'd4)  begin cls = 5; alu = 3'd1; end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input out_t o);
        exp_t e;
        e.cyc = c;
        e.o   = o;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with visible activity must match the head of the queue.
    logic halted_q = 1'b0;
    always @(negedge clk) begin
        out_t o;
        exp_t e;
        o = dut_out();
        if (o.ir_write | o.pc_write | o.reg_write | o.mem_req | (o.halted & ~halted_q)) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: cycle %0d got %h expected no activity", cyc, o);
            end else begin
                e = sbq.pop_front();
                if (e.cyc != cyc || o !== e.o) begin
                    n_fail++;
                    $display("FAIL output_event: cycle %0d got %h, expected cycle %0d value %h",
                             cyc, o, e.cyc, e.o);
                end
            end
        end
        halted_q = o.halted;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
            zero = 1'($urandom); mem_ready = 1'($urandom);
            step();
        end
    endtask

    // Issue one instruction starting in a FETCH cycle; w = memory wait cycles,
    // z = zero flag during EXEC, tmo = memory never answers.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int w, input logic z, input bit tmo);
        int         cls, t0, len, nmem;
        logic [2:0] alu;
        logic [1:0] mr;
        out_t       o;
        bit         halts;
        classify(op, fn, cls, alu, mr);
        t0 = cyc;
        halts = 1'b0;
        o = '0; o.ir_write = 1'b1; push(t0, o);
        case (cls)
            0: begin
                o = '0; o.halted = 1'b1; o.fault = 2'd1; push(t0 + 2, o);
                len = 2; halts = 1'b1;
            end
            1, 2: begin
                o = '0; o.reg_write = 1'b1; o.pc_write = 1'b1; o.reg_dst = (cls == 1);
                o.alu_sel = alu; o.alu_src = (cls == 2); push(t0 + 3, o);
                len = 4;
            end
            5: begin
                o = '0; o.pc_write = 1'b1; o.pc_src = z; o.alu_sel = 3'd1; push(t0 + 2, o);
                len = 3;
            end
            default: begin
                nmem = tmo ? TMO : w + 1;
                for (int k = 0; k < nmem; k++) begin
                    o = '0; o.mem_req = 1'b1; o.alu_src = 1'b1; o.mem_read = mr;
                    o.mem_write = (cls == 4);
                    o.pc_write = (cls == 4 && !tmo && k == w);
                    push(t0 + 3 + k, o);
                end
                if (tmo) begin
                    o = '0; o.halted = 1'b1; o.fault = 2'd2; push(t0 + 3 + TMO, o);
                    len = 3 + TMO; halts = 1'b1;
                end else if (cls == 3) begin
                    o = '0; o.reg_write = 1'b1; o.pc_write = 1'b1; o.mem_to_reg = 1'b1;
                    o.mem_read = mr; o.alu_src = 1'b1; push(t0 + 4 + w, o);
                    len = 5 + w;
                end else begin
                    len = 4 + w;
                end
            end
        endcase
        for (int i = 0; i < len; i++) begin
            if (i == 0) begin
                opcode = op; funct = fn; run = 1'b1;
            end else begin
                opcode = 6'($urandom); funct = 6'($urandom); run = 1'($urandom);
            end
            zero = (i == 2) ? z : 1'($urandom);
            if ((cls == 3 || cls == 4) && i >= 3 && (tmo || i <= 3 + w))
                mem_ready = (!tmo && i == 3 + w);
            else
                mem_ready = 1'($urandom);
            step();
        end
        if (halts) begin
            for (int i = 0; i < 4; i++) begin
                run = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom);
                mem_ready = 1'($urandom); zero = 1'($urandom);
                step();
            end
            @(negedge clk);
            check("halt_sticky", {halted, fault, state},
                  {1'b1, (cls == 0) ? 2'd1 : 2'd2, 3'd5});
            step();
            reset = 1'b0; run = 1'b0;
            step();
            step();
            reset = 1'b1;
            @(negedge clk);
            check("reset_after_halt", {dut_out(), state}, 64'd0);
            step();
        end
    endtask

    initial begin
        int         t0, r;
        out_t       o;
        logic [5:0] op, fn;

        reset = 1'b0; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        step(); step(); step();
        @(negedge clk);
        check("reset_state", {dut_out(), state}, 64'd0);
        step();
        run = 1'b1; opcode = 6'd8; mem_ready = 1'b1;
        @(negedge clk);
        check("reset_gates_ir_write", {dut_out(), state}, 64'd0);
        step();
        reset = 1'b1; mem_ready = 1'b0;

        run_instr(6'b001000, 6'd0, 0, 1'b0, 1'b0);      // ADDI
        run_instr(6'b000100, 6'd0, 0, 1'b1, 1'b0);      // BEQ taken
        run_instr(6'b000100, 6'd0, 0, 1'b0, 1'b0);      // BEQ not taken
        run_instr(6'b100011, 6'd0, 3, 1'b0, 1'b0);      // LW, 3 wait cycles
        run_instr(6'b101011, 6'd0, 0, 1'b0, 1'b1);      // SW, memory timeout
        run_instr(6'b111111, 6'd0, 0, 1'b0, 1'b0);      // illegal opcode
        run_instr(6'b000000, 6'b001000, 0, 1'b0, 1'b0); // illegal funct
        run_instr(6'b000000, 6'b100010, 0, 1'b0, 1'b0); // SUB
        run_instr(6'b101011, 6'd0, 0, 1'b0, 1'b0);      // SW, no wait

        // LH aborted by reset during MEM, then idle with run low.
        t0 = cyc;
        o = '0; o.ir_write = 1'b1; push(t0, o);
        for (int k = 0; k < 2; k++) begin
            o = '0; o.mem_req = 1'b1; o.alu_src = 1'b1; o.mem_read = 2'd2; push(t0 + 3 + k, o);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin opcode = 6'b100001; funct = 6'd0; run = 1'b1; end
            else begin opcode = 6'($urandom); funct = 6'($urandom); end
            mem_ready = (i >= 3) ? 1'b0 : 1'($urandom);
            step();
        end
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("reset_abort", {ir_write, pc_write, reg_write, mem_req}, 64'd0);
        step();
        reset = 1'b1; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", {dut_out(), state}, 64'd0);
`ifdef MC_CONTROL_PERF_EN
            check("instr_count_reset", instr_count, 64'd0);
`endif
            step();
        end
        mem_ready = 1'b0;

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                op = 6'($urandom); fn = 6'($urandom);
                run_instr(op, fn, $urandom_range(0, 5), 1'($urandom), 1'b0);
            end else if (r == 1) begin
                op = mem_ops[$urandom_range(0, 3)];
                run_instr(op, 6'($urandom), 0, 1'b0, 1'b1);
            end else begin
                op = legal_ops[$urandom_range(0, 10)];
                fn = (op == 6'd0) ? 6'(rfn[$urandom_range(0, 7)]) : 6'($urandom);
                run_instr(op, fn, $urandom_range(0, 5), 1'($urandom), 1'b0);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(5);
        check("scoreboard_drained", sbq.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
